// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS memory-mapped I/O block: register offsets,
// STATUS bit positions and the default base address of the I/O window.
package mips_io_pkg;

  localparam logic [31:0] DEFAULT_IO_BASE_ADDR = 32'h1001_0100;

  localparam logic [2:0] OFF_PORT_OUT = 3'd0;
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_TX_DATA  = 3'd3;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd4;

  localparam int ST_IN_CHG   = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_OVF   = 3;

endpackage

// File: rtl/port_io_fifo.sv
// Small synchronous FIFO for the I/O transmit path. A push into a full FIFO
// is accepted only when a pop happens in the same cycle; head reads 0 when empty.
module port_io_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; head is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign head = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/mips_port_io.sv
// Memory-mapped I/O peripheral: PortOut latch, synchronised PortIn with change
// detection and a TX FIFO. Macro PORT_IO_IRQ_EN enables the IRQ_EN register and InChangeIrq.
module mips_port_io
  import mips_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE_ADDR  = DEFAULT_IO_BASE_ADDR,
  parameter int          PORT_IN_WIDTH = 8,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              Address,
  input  logic [31:0]              WriteData,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  output logic [31:0]              ReadData,
  output logic                     Hit,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic [31:0]              TxData,
  output logic                     TxValid,
  input  logic                     TxReady,
  output logic                     InChangeIrq
);

  logic [2:0]               offset;
  logic                     wrEn;
  logic                     wrPortOut;
  logic                     wrStatus;
  logic                     pushTx;
  logic                     popTx;
  logic [PORT_IN_WIDTH-1:0] sync1;
  logic [PORT_IN_WIDTH-1:0] sync2;
  logic [PORT_IN_WIDTH-1:0] syncPrev;
  logic                     inChg;
  logic                     txOvf;
  logic                     txFull;
  logic                     txEmpty;
  logic                     irqEn;
  logic [31:0]              statusReg;

  assign Hit       = (Address[31:5] == IO_BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
  assign offset    = Address[4:2];
  assign wrEn      = MemWrite & Hit;
  assign wrPortOut = wrEn && (offset == OFF_PORT_OUT);
  assign wrStatus  = wrEn && (offset == OFF_STATUS);
  assign pushTx    = wrEn && (offset == OFF_TX_DATA);
  assign TxValid   = ~txEmpty;
  assign popTx     = TxValid & TxReady;

  // syncPrev holds last cycle's stage-2 value so a difference marks an input change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      syncPrev <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's pre-edge value.
      sync1    <= PortIn;
      sync2    <= sync1;
      syncPrev <= sync2;
    end
  end

  // Sticky flags: a fresh set event wins over a same-cycle write-one-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut <= '0;
      inChg   <= 1'b0;
      txOvf   <= 1'b0;
    end else begin
      if (wrPortOut) PortOut <= WriteData;

      if (sync2 != syncPrev)                    inChg <= 1'b1;
      else if (wrStatus && WriteData[ST_IN_CHG]) inChg <= 1'b0;

      if (pushTx && txFull && !popTx)           txOvf <= 1'b1;
      else if (wrStatus && WriteData[ST_TX_OVF]) txOvf <= 1'b0;
    end
  end

  port_io_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_txFifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (pushTx),
    .pop      (popTx),
    .pushData (WriteData),
    .full     (txFull),
    .empty    (txEmpty),
    .head     (TxData)
  );

`ifdef PORT_IO_IRQ_EN
  logic wrIrqEn;
  assign wrIrqEn = wrEn && (offset == OFF_IRQ_EN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       irqEn <= 1'b0;
    else if (wrIrqEn) irqEn <= WriteData[0];
  end

  assign InChangeIrq = irqEn & inChg;
`else
  assign irqEn       = 1'b0;
  assign InChangeIrq = 1'b0;
`endif

  always_comb begin
    statusReg              = '0;
    statusReg[ST_IN_CHG]   = inChg;
    statusReg[ST_TX_FULL]  = txFull;
    statusReg[ST_TX_EMPTY] = txEmpty;
    statusReg[ST_TX_OVF]   = txOvf;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives ReadData and no latch is inferred.
    ReadData = '0;
    if (MemRead && Hit) begin
      case (offset)
        OFF_PORT_OUT: ReadData = PortOut;
        OFF_PORT_IN:  ReadData = 32'(sync2);
        OFF_STATUS:   ReadData = statusReg;
        OFF_IRQ_EN:   ReadData = {31'b0, irqEn};
        default:      ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_port_io.sv
// Self-checking bench for mips_port_io: directed scenarios plus random bus traffic,
// checked by a scoreboard fed from a queue-based reference model.
`timescale 1ns/1ps
module tb_mips_port_io;
  import mips_io_pkg::*;

  localparam logic [31:0] BASE  = DEFAULT_IO_BASE_ADDR;
  localparam int          DEPTH = 4;
`ifdef PORT_IO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic [31:0] TxData;
  logic        TxValid;
  logic        TxReady;
  logic        InChangeIrq;

  mips_port_io #(
    .IO_BASE_ADDR  (BASE),
    .PORT_IN_WIDTH (8),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .ReadData    (ReadData),
    .Hit         (Hit),
    .PortIn      (PortIn),
    .PortOut     (PortOut),
    .TxData      (TxData),
    .TxValid     (TxValid),
    .TxReady     (TxReady),
    .InChangeIrq (InChangeIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain variables and queues following the register-map rules.
  logic [31:0] mPortOut;
  logic [31:0] mFifo[$];
  logic        mOvf;
  logic        mInChg;
  logic        mIrqEn;
  logic [7:0]  mHist[$];   // PortIn values seen at past clock edges, newest first

  typedef struct {
    logic        hit;
    logic [31:0] rd;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] txQ[$];

  logic [7:0]  pinCur;
  logic        rdyCur;

  function automatic logic isHit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd32) && ((a % 32'd4) == 32'd0);
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] a, input logic re);
    logic [31:0] idx;
    if (!(re && isHit(a))) return 32'h0;
    idx = (a - BASE) / 32'd4;
    case (idx)
      32'd0:   return mPortOut;
      32'd1:   return {24'h0, mHist[1]};
      32'd2:   return {28'h0, mOvf, mFifo.size() == 0, mFifo.size() == DEPTH, mInChg};
      32'd4:   return {31'h0, mIrqEn};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mPortOut = 32'h0;
    mFifo.delete();
    mOvf   = 1'b0;
    mInChg = 1'b0;
    mIrqEn = 1'b0;
    mHist  = {8'h00, 8'h00, 8'h00};
  endtask

  // Applies one clock edge to the model using the inputs presented before it.
  task automatic modelEdge();
    logic        wr;
    logic [31:0] idx;
    logic        pop;
    logic        full;
    logic        chg;
    logic        ovfSet;
    wr     = MemWrite && isHit(Address);
    idx    = (Address - BASE) / 32'd4;
    pop    = TxReady && (mFifo.size() > 0);
    full   = (mFifo.size() == DEPTH);
    chg    = (mHist[1] != mHist[2]);
    ovfSet = 1'b0;
    if (pop) mFifo.delete(0);
    if (wr && idx == 32'd3) begin
      if (!full || pop) mFifo.push_back(WriteData);
      else ovfSet = 1'b1;
    end
    if (wr && idx == 32'd0) mPortOut = WriteData;
    if (wr && idx == 32'd4 && IRQ_BUILD) mIrqEn = WriteData[0];
    if (wr && idx == 32'd2) begin
      if (WriteData[0]) mInChg = 1'b0;
      if (WriteData[3]) mOvf   = 1'b0;
    end
    if (chg)    mInChg = 1'b1;
    if (ovfSet) mOvf   = 1'b1;
    mHist = {PortIn, mHist[0], mHist[1]};
  endtask

  // One bus cycle: called just after a rising edge, returns at the next edge + 1.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic re, output logic [31:0] rdSeen, output logic hitSeen);
    exp_t e;
    Address   = a;
    WriteData = d;
    MemWrite  = we;
    MemRead   = re;
    TxReady   = rdyCur;
    PortIn    = pinCur;
    e.hit = isHit(a);
    e.rd  = expRead(a, re);
    expQ.push_back(e);
    if (rdyCur && mFifo.size() > 0) txQ.push_back(mFifo[0]);
    #2;
    rdSeen  = ReadData;
    hitSeen = Hit;
    @(posedge clk);
    modelEdge();
    #1;
    check("PortOut", PortOut, mPortOut);
    checkBit("TxValid", TxValid, mFifo.size() > 0);
    check("TxData", TxData, (mFifo.size() > 0) ? mFifo[0] : 32'h0);
    checkBit("InChangeIrq", InChangeIrq, mInChg & mIrqEn);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] r;
    logic        h;
    cycle(BASE + 32'(off) * 32'd4, d, 1'b1, 1'b0, r, h);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] r);
    logic h;
    cycle(BASE + 32'(off) * 32'd4, 32'h0, 1'b0, 1'b1, r, h);
  endtask

  task automatic idle();
    logic [31:0] r;
    logic        h;
    cycle(32'h0, 32'h0, 1'b0, 1'b0, r, h);
  endtask

  task automatic doReset();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    TxReady  = 1'b0;
    PortIn   = pinCur;
    reset    = 1'b0;
    #1;
    modelReset();
    check("rst_PortOut", PortOut, 32'h0);
    checkBit("rst_TxValid", TxValid, 1'b0);
    check("rst_TxData", TxData, 32'h0);
    checkBit("rst_InChangeIrq", InChangeIrq, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Scoreboard monitor: compares bus responses and TX handshakes at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkBit("Hit", Hit, e.hit);
        check("ReadData", ReadData, e.rd);
      end
      if (TxValid === 1'b1 && TxReady === 1'b1) begin
        if (txQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("FAIL TxPop: unexpected pop of %08h at %0t", TxData, $time);
        end else begin
          check("TxPop", TxData, txQ.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r;
    logic        h;
    logic [31:0] a;
    logic [31:0] drainExp [4];
    int          k;

    reset     = 1'b1;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    TxReady   = 1'b0;
    PortIn    = 8'h00;
    pinCur    = 8'h00;
    rdyCur    = 1'b0;
    #1;
    doReset();

    // PORT_OUT write/readback and misaligned miss
    wr(OFF_PORT_OUT, 32'hDEAD_BEEF);
    check("t2_portout", PortOut, 32'hDEAD_BEEF);
    rd(OFF_PORT_OUT, r);
    check("t2_readback", r, 32'hDEAD_BEEF);
    cycle(BASE + 32'd2, 32'h0, 1'b0, 1'b1, r, h);
    checkBit("t2_misaligned_hit", h, 1'b0);
    check("t2_misaligned_rd", r, 32'h0);

    // PortIn synchronisation latency and change detection
    pinCur = 8'hA5;
    idle();
    rd(OFF_PORT_IN, r);
    check("t3_port_in_early", r, 32'h0);
    rd(OFF_PORT_IN, r);
    check("t3_port_in", r, 32'hA5);
    rd(OFF_STATUS, r);
    checkBit("t3_in_chg", r[ST_IN_CHG], 1'b1);
    pinCur = 8'h5A;
    idle();
    idle();
    wr(OFF_STATUS, 32'h1);
    rd(OFF_STATUS, r);
    checkBit("t3_set_wins", r[ST_IN_CHG], 1'b1);
    wr(OFF_STATUS, 32'h1);
    rd(OFF_STATUS, r);
    checkBit("t3_w1c", r[ST_IN_CHG], 1'b0);

    // Interrupt path
`ifdef PORT_IO_IRQ_EN
    wr(OFF_IRQ_EN, 32'hFFFF_FFFF);
    rd(OFF_IRQ_EN, r);
    check("t6_irq_en_rd", r, 32'h1);
    pinCur = 8'h3C;
    idle();
    idle();
    idle();
    checkBit("t6_irq_set", InChangeIrq, 1'b1);
    wr(OFF_STATUS, 32'h1);
    checkBit("t6_irq_clr", InChangeIrq, 1'b0);
`else
    wr(OFF_IRQ_EN, 32'hFFFF_FFFF);
    rd(OFF_IRQ_EN, r);
    check("t6_irq_en_rd", r, 32'h0);
    pinCur = 8'h3C;
    idle();
    idle();
    idle();
    checkBit("t6_irq_tied", InChangeIrq, 1'b0);
    rd(OFF_STATUS, r);
    checkBit("t6_in_chg", r[ST_IN_CHG], 1'b1);
    wr(OFF_STATUS, 32'h1);
`endif

    // FIFO fill, overflow, then drain
    rdyCur = 1'b0;
    for (int i = 1; i <= 4; i++) wr(OFF_TX_DATA, 32'(i));
    rd(OFF_STATUS, r);
    checkBit("t4_full", r[ST_TX_FULL], 1'b1);
    checkBit("t4_no_ovf", r[ST_TX_OVF], 1'b0);
    wr(OFF_TX_DATA, 32'd5);
    rd(OFF_STATUS, r);
    checkBit("t4_ovf", r[ST_TX_OVF], 1'b1);
    rdyCur = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t4_head", TxData, 32'(i));
      idle();
    end
    checkBit("t4_empty", TxValid, 1'b0);
    rdyCur = 1'b0;
    wr(OFF_STATUS, 32'h8);
    rd(OFF_STATUS, r);
    check("t4_status_clean", r, 32'h4);

    // Push on full with a simultaneous pop
    for (int i = 0; i < 4; i++) wr(OFF_TX_DATA, 32'(11 + i));
    rdyCur = 1'b1;
    wr(OFF_TX_DATA, 32'd9);
    rdyCur = 1'b0;
    rd(OFF_STATUS, r);
    checkBit("t5_still_full", r[ST_TX_FULL], 1'b1);
    checkBit("t5_no_ovf", r[ST_TX_OVF], 1'b0);
    drainExp = '{32'd12, 32'd13, 32'd14, 32'd9};
    rdyCur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain", TxData, drainExp[i]);
      idle();
    end
    checkBit("t5_empty", TxValid, 1'b0);

    // Reset mid-run with two FIFO entries pending
    rdyCur = 1'b0;
    wr(OFF_TX_DATA, 32'h77);
    wr(OFF_TX_DATA, 32'h88);
    checkBit("t1_pending", TxValid, 1'b1);
    pinCur = 8'h00;
    doReset();
    rd(OFF_STATUS, r);
    check("t1_status", r, 32'h4);

    // Random bus traffic against the model
    for (int n = 0; n < 400; n++) begin
      k      = int'($urandom_range(0, 99));
      rdyCur = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) pinCur = 8'($urandom);
      if (k < 35) a = BASE + 32'd12;
      else        a = BASE + 32'($urandom_range(0, 7)) * 32'd4;
      if (k >= 90 && k < 95) a = a + 32'($urandom_range(1, 3));
      else if (k >= 95)      a = $urandom;
      cycle(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, h);
    end

    rdyCur = 1'b1;
    repeat (6) idle();
    @(negedge clk);
    #1;
    check("expq_drained", 32'(expQ.size()), 32'h0);
    check("txq_drained", 32'(txQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
